muldiv_unit: RTL and testbench

- Parametrised HI/LO multiply/divide unit for the pipelined MIPS core; sits beside the EX-stage ALU and owns the HI and LO registers.
- Multiplies use a configurable pipelined latency. Division is a true iterative shift-subtract engine, one quotient bit per cycle.
- Adds multiply-accumulate/subtract (madd/maddu/msub/msubu) and a busy/countdown interface for the hazard unit. HI/LO are written only on completion.

---
 rtl/muldiv_unit.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: pipelined-latency multiply (with accumulate) and iterative restoring divide.
// Define MULDIV_CANCEL_EN to add the flush port for cancelling an in-flight operation.
module muldiv_unit #(
   parameter int WIDTH       = 32,
   parameter int MUL_LATENCY = 5,
   parameter int CNT_W       = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [3:0]        op,
   input  logic              start,
   input  logic              rd_lo,
`ifdef MULDIV_CANCEL_EN
   input  logic              flush,
`endif
   output logic [WIDTH-1:0]  s,
   output logic              busy,
   output logic [CNT_W-1:0]  count,
   output logic              done
);

   localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2, OP_DIV   = 4'd3, OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MADD  = 4'd5, OP_MADDU = 4'd6, OP_MSUB  = 4'd7, OP_MSUBU = 4'd8;
   localparam logic [3:0] OP_MTHI  = 4'd9, OP_MTLO  = 4'd10;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {MUL_SET, MUL_ADD, MUL_SUB} mul_kind_e;

   logic              flush_i;
`ifdef MULDIV_CANCEL_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               done_q, done_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   mul_kind_e          mul_kind_q, mul_kind_d;
   logic               is_div_q, is_div_d;
   logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, divisor_q, divisor_d, a_raw_q, a_raw_d;
   logic               neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, div_zero_q, div_zero_d;

   // Operand conditioning for launch: sign-extended multiply and magnitude/sign split for divide.
   logic               mul_signed, div_signed, a_neg, b_neg;
   logic [2*WIDTH-1:0] ext_a, ext_b, prod_full, acc, mul_result;
   logic [WIDTH-1:0]   a_abs, b_abs;

   assign mul_signed = (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
   assign ext_a      = mul_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
   assign ext_b      = mul_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
   assign prod_full  = ext_a * ext_b;
   assign div_signed = (op == OP_DIV);
   assign a_neg      = div_signed & a[WIDTH-1];
   assign b_neg      = div_signed & b[WIDTH-1];
   assign a_abs      = a_neg ? -a : a;
   assign b_abs      = b_neg ? -b : b;

   assign acc = {hi_q, lo_q};
   always_comb begin
      mul_result = prod_q;
      case (mul_kind_q)
         MUL_ADD: mul_result = acc + prod_q;
         MUL_SUB: mul_result = acc - prod_q;
         default: mul_result = prod_q;
      endcase
   end

   // One restoring step: the dividend shifts out of quo while quotient bits shift in.
   logic [WIDTH:0]   div_shift;
   logic             div_fits;
   logic [WIDTH-1:0] step_rem, step_quo;

   assign div_shift = {rem_q, quo_q[WIDTH-1]};
   assign div_fits  = div_shift >= {1'b0, divisor_q};
   assign step_rem  = div_fits ? WIDTH'(div_shift - {1'b0, divisor_q}) : div_shift[WIDTH-1:0];
   assign step_quo  = {quo_q[WIDTH-2:0], div_fits};

   always_comb begin
      hi_d       = hi_q;
      lo_d       = lo_q;
      count_d    = count_q;
      done_d     = 1'b0;
      prod_d     = prod_q;
      mul_kind_d = mul_kind_q;
      is_div_d   = is_div_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      divisor_d  = divisor_q;
      a_raw_d    = a_raw_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      div_zero_d = div_zero_q;
      if (flush_i) begin
         count_d = '0;
      end else if (count_q != '0) begin
         count_d = count_q - CNT_ONE;
         if (count_q == CNT_ONE) begin
            done_d = 1'b1;
            if (!is_div_q) begin
               {hi_d, lo_d} = mul_result;
            end else if (div_zero_q) begin
               lo_d = '1;
               hi_d = a_raw_q;
            end else begin
               lo_d = neg_quo_q ? -quo_q : quo_q;
               hi_d = neg_rem_q ? -rem_q : rem_q;
            end
         end else if (is_div_q) begin
            rem_d = step_rem;
            quo_d = step_quo;
         end
      end else if (start) begin
         case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
               prod_d     = prod_full;
               is_div_d   = 1'b0;
               count_d    = CNT_W'(MUL_LATENCY);
               mul_kind_d = (op == OP_MADD || op == OP_MADDU) ? MUL_ADD :
                            (op == OP_MSUB || op == OP_MSUBU) ? MUL_SUB : MUL_SET;
            end
            OP_DIV, OP_DIVU: begin
               is_div_d   = 1'b1;
               count_d    = CNT_W'(WIDTH + 1);
               rem_d      = '0;
               quo_d      = a_abs;
               divisor_d  = b_abs;
               a_raw_d    = a;
               neg_quo_d  = a_neg ^ b_neg;
               neg_rem_d  = a_neg;
               div_zero_d = (b == '0);
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q       <= '0;
         lo_q       <= '0;
         count_q    <= '0;
         done_q     <= 1'b0;
         prod_q     <= '0;
         mul_kind_q <= MUL_SET;
         is_div_q   <= 1'b0;
         rem_q      <= '0;
         quo_q      <= '0;
         divisor_q  <= '0;
         a_raw_q    <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         count_q    <= count_d;
         done_q     <= done_d;
         prod_q     <= prod_d;
         mul_kind_q <= mul_kind_d;
         is_div_q   <= is_div_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         divisor_q  <= divisor_d;
         a_raw_q    <= a_raw_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign s     = rd_lo ? lo_q : hi_q;
   assign busy  = start | (count_q != '0);
   assign count = count_q;
   assign done  = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit; flush scenarios are included when MULDIV_CANCEL_EN is defined.
module tb_muldiv_unit;
   localparam int W  = 32;
   localparam int CW = 6;
   localparam int ML = 5;

   logic          clk = 1'b0;
   logic          reset, start, rd_lo, busy, done;
   logic [W-1:0]  a, b, s;
   logic [3:0]    op;
   logic [CW-1:0] count;
`ifdef MULDIV_CANCEL_EN
   logic          flush;
`endif
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W), .MUL_LATENCY(ML), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .start(start), .rd_lo(rd_lo),
`ifdef MULDIV_CANCEL_EN
      .flush(flush),
`endif
      .s(s), .busy(busy), .count(count), .done(done)
   );

   // Reads both committed registers through the s mux, away from the clock edge.
   task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
      rd_lo = 1'b0; #1 hi = s;
      rd_lo = 1'b1; #1 lo = s;
      rd_lo = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the launch edge.
   task automatic launch(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(negedge clk);
      start = 1'b0; op = 4'd0;
   endtask

   task automatic test_reset();
      logic [W-1:0] hi, lo;
      read_hilo(hi, lo);
      n_vec++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("[TB] FAIL reset_hilo: got %h_%h want 0_0", hi, lo); end
      n_vec++; if (count !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ctl: got count=%0d busy=%b done=%b want 0/0/0", count, busy, done); end
   endtask

   task automatic test_mul(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input string name);
      logic [W-1:0] hi0, lo0, hi, lo;
      read_hilo(hi0, lo0);
      launch(o, x, y);
      for (int i = ML; i >= 1; i--) begin
         n_vec++; if (count !== CW'(i) || busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("[TB] FAIL %s_count: got count=%0d busy=%b done=%b want %0d/1/0", name, count, busy, done, i); end
         @(negedge clk);
      end
      read_hilo(hi, lo);
      n_vec++; if (count !== 6'd0 || done !== 1'b1) begin n_err++; $display("[TB] FAIL %s_done: got count=%0d done=%b want 0/1", name, count, done); end
      n_vec++; if (hi !== exp_hi || lo !== exp_lo) begin n_err++; $display("[TB] FAIL %s_result: got %h_%h want %h_%h (prev %h_%h)", name, hi, lo, exp_hi, exp_lo, hi0, lo0); end
      @(negedge clk);
      n_vec++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL %s_pulse: got done=%b want 0", name, done); end
   endtask

   task automatic test_div(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input string name);
      logic [W-1:0] hi0, lo0, hi, lo;
      read_hilo(hi0, lo0);
      launch(o, x, y);
      n_vec++; if (count !== 6'd33) begin n_err++; $display("[TB] FAIL %s_start: got count=%0d want 33", name, count); end
      repeat (W) @(negedge clk);
      read_hilo(hi, lo);
      n_vec++; if (count !== 6'd1 || hi !== hi0 || lo !== lo0) begin n_err++; $display("[TB] FAIL %s_busy: got count=%0d %h_%h want 1 %h_%h", name, count, hi, lo, hi0, lo0); end
      @(negedge clk);
      read_hilo(hi, lo);
      n_vec++; if (count !== 6'd0 || done !== 1'b1) begin n_err++; $display("[TB] FAIL %s_done: got count=%0d done=%b want 0/1", name, count, done); end
      n_vec++; if (hi !== exp_hi || lo !== exp_lo) begin n_err++; $display("[TB] FAIL %s_result: got %h_%h want %h_%h", name, hi, lo, exp_hi, exp_lo); end
      @(negedge clk);
      n_vec++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL %s_pulse: got done=%b want 0", name, done); end
   endtask

   task automatic test_move(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo, input string name);
      logic [W-1:0] hi, lo;
      launch(o, x, 32'h0);
      read_hilo(hi, lo);
      n_vec++; if (hi !== exp_hi || lo !== exp_lo || count !== 6'd0 || busy !== 1'b0) begin n_err++; $display("[TB] FAIL %s: got %h_%h count=%0d busy=%b want %h_%h 0/0", name, hi, lo, count, busy, exp_hi, exp_lo); end
      @(negedge clk);
      n_vec++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL %s_nodone: got done=%b want 0", name, done); end
   endtask

   task automatic test_none();
      logic [W-1:0] hi0, lo0, hi, lo;
      read_hilo(hi0, lo0);
      start = 1'b1; op = 4'd12; a = 32'hFFFF_FFFF; b = 32'h1;
      #1;
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL none_busy: got busy=%b want 1", busy); end
      @(negedge clk);
      start = 1'b0; op = 4'd0;
      read_hilo(hi, lo);
      n_vec++; if (busy !== 1'b0 || count !== 6'd0 || hi !== hi0 || lo !== lo0) begin n_err++; $display("[TB] FAIL none_effect: got busy=%b count=%0d %h_%h want 0/0 %h_%h", busy, count, hi, lo, hi0, lo0); end
      @(negedge clk);
      n_vec++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL none_nodone: got done=%b want 0", done); end
   endtask

   task automatic test_ignored_start();
      logic [W-1:0] hi0, lo0, hi, lo;
      read_hilo(hi0, lo0);
      launch(4'd1, 32'd3, 32'd4);
      @(negedge clk);
      start = 1'b1; op = 4'd9; a = 32'hDEAD;
      @(negedge clk);
      start = 1'b0; op = 4'd0;
      read_hilo(hi, lo);
      n_vec++; if (count !== 6'd3 || hi !== hi0 || lo !== lo0) begin n_err++; $display("[TB] FAIL ignored_start: got count=%0d %h_%h want 3 %h_%h", count, hi, lo, hi0, lo0); end
      repeat (3) @(negedge clk);
      read_hilo(hi, lo);
      n_vec++; if (done !== 1'b1 || hi !== 32'h0 || lo !== 32'd12) begin n_err++; $display("[TB] FAIL ignored_result: got done=%b %h_%h want 1 0_c", done, hi, lo); end
      @(negedge clk);
   endtask

   task automatic test_reset_midflight();
      logic [W-1:0] hi, lo;
      launch(4'd3, 32'd100, 32'd7);
      repeat (23) @(negedge clk);
      n_vec++; if (count !== 6'd10) begin n_err++; $display("[TB] FAIL midreset_count: got %0d want 10", count); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      read_hilo(hi, lo);
      n_vec++; if (hi !== 32'h0 || lo !== 32'h0 || count !== 6'd0 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_state: got %h_%h count=%0d busy=%b done=%b want 0_0 0/0/0", hi, lo, count, busy, done); end
      repeat (40) @(negedge clk);
      read_hilo(hi, lo);
      n_vec++; if (hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin n_err++; $display("[TB] FAIL midreset_nocommit: got %h_%h done=%b want 0_0 0", hi, lo, done); end
   endtask

`ifdef MULDIV_CANCEL_EN
   task automatic test_cancel();
      logic [W-1:0] hi, lo;
      logic         saw_done;
      test_move(4'd9, 32'h55, 32'h55, 32'h0, "mthi55");
      test_move(4'd10, 32'h55, 32'h55, 32'h55, "mtlo55");
      launch(4'd4, 32'd9, 32'd2);
      repeat (13) @(negedge clk);
      n_vec++; if (count !== 6'd20) begin n_err++; $display("[TB] FAIL flush_count: got %0d want 20", count); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      read_hilo(hi, lo);
      n_vec++; if (count !== 6'd0 || hi !== 32'h55 || lo !== 32'h55) begin n_err++; $display("[TB] FAIL flush_state: got count=%0d %h_%h want 0 55_55", count, hi, lo); end
      saw_done = 1'b0;
      for (int i = 0; i < 40; i++) begin @(negedge clk); saw_done |= done; end
      read_hilo(hi, lo);
      n_vec++; if (saw_done !== 1'b0 || hi !== 32'h55 || lo !== 32'h55) begin n_err++; $display("[TB] FAIL flush_nocommit: got done_seen=%b %h_%h want 0 55_55", saw_done, hi, lo); end
      flush = 1'b1; start = 1'b1; op = 4'd1; a = 32'd3; b = 32'd3;
      @(negedge clk);
      flush = 1'b0; start = 1'b0; op = 4'd0;
      n_vec++; if (count !== 6'd0 || busy !== 1'b0) begin n_err++; $display("[TB] FAIL flush_start: got count=%0d busy=%b want 0/0", count, busy); end
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin @(negedge clk); saw_done |= done; end
      read_hilo(hi, lo);
      n_vec++; if (saw_done !== 1'b0 || hi !== 32'h55 || lo !== 32'h55) begin n_err++; $display("[TB] FAIL flush_start_nolaunch: got done_seen=%b %h_%h want 0 55_55", saw_done, hi, lo); end
   endtask
`endif

   initial begin
      reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0; rd_lo = 1'b0;
`ifdef MULDIV_CANCEL_EN
      flush = 1'b0;
`endif
      repeat (2) @(negedge clk);
      test_reset();
      reset = 1'b0;
      @(negedge clk);
      test_mul(4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
      test_mul(4'd2, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
      test_div(4'd4, 32'd100, 32'd7, 32'd2, 32'd14, "divu");
      test_div(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
      test_div(4'd3, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, "div_neg100");
      test_div(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_min");
      test_div(4'd3, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, "div_zero");
      test_div(4'd4, 32'h8000_0001, 32'h0, 32'h8000_0001, 32'hFFFF_FFFF, "divu_zero");
      test_move(4'd9, 32'd5, 32'd5, 32'hFFFF_FFFF, "mthi");
      test_move(4'd10, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, "mtlo");
      test_mul(4'd6, 32'd1, 32'd1, 32'd6, 32'd0, "maddu");
      test_mul(4'd7, 32'd1, 32'd2, 32'd5, 32'hFFFF_FFFE, "msub");
      test_mul(4'd5, 32'hFFFF_FFFF, 32'd1, 32'd5, 32'hFFFF_FFFD, "madd");
      test_mul(4'd8, 32'hFFFF_FFFF, 32'd2, 32'd3, 32'hFFFF_FFFF, "msubu");
      test_none();
      test_ignored_start();
      test_reset_midflight();
`ifdef MULDIV_CANCEL_EN
      test_cancel();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
